// File: rtl/if_fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
// Each 32-bit instruction is fetched as four little-endian byte reads.
package if_fetch_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;
    localparam int unsigned MEM_BYTE_W  = 8;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    typedef enum logic [2:0] {
        IF_REQ0  = 3'd0,
        IF_REQ1  = 3'd1,
        IF_REQ2  = 3'd2,
        IF_REQ3  = 3'd3,
        IF_WAIT  = 3'd4,
        IF_VALID = 3'd5
    } if_state_e;

    // Byte lane requested by a REQk state.
    function automatic logic [1:0] req_index(input if_state_e s);
        case (s)
            IF_REQ1: return 2'd1;
            IF_REQ2: return 2'd2;
            IF_REQ3: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic if_state_e req_next(input if_state_e s);
        case (s)
            IF_REQ0: return IF_REQ1;
            IF_REQ1: return IF_REQ2;
            IF_REQ2: return IF_REQ3;
            default: return IF_WAIT;
        endcase
    endfunction

endpackage

// File: rtl/if_fetch.sv
// RV32I instruction fetch: four byte reads over the shared 8-bit memory port,
// one instruction presented to IF/ID at a time, abandoned on any redirect.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   branch_sig_i,
    input  logic [INST_ADDR_W-1:0] branch_addr_i,
    input  logic                   stall_i,
    input  logic                   mem_gnt_i,
    input  logic [MEM_BYTE_W-1:0]  mem_data_i,
    output logic                   mem_rd_o,
    output logic [INST_ADDR_W-1:0] mem_addr_o,
    output logic                   if_valid_o,
    output logic [INST_ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0]      if_inst_o
);

    if_state_e              state;
    logic [INST_ADDR_W-1:0] pc;
    logic                   in_flight;
    logic [1:0]             flight_tag;

    logic                   granted;
    logic [1:0]             req_k;
    logic [INST_ADDR_W-1:0] branch_pc;
    logic                   unused_addr_bits;

    assign granted          = mem_rd_o && mem_gnt_i;
    assign req_k            = req_index(state);
    assign branch_pc        = {branch_addr_i[INST_ADDR_W-1:2], 2'b00};
    assign unused_addr_bits = ^branch_addr_i[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IF_REQ0;
            pc         <= RESET_PC;
            in_flight  <= 1'b0;
            flight_tag <= 2'd0;
            if_valid_o <= 1'b0;
            if_inst_o  <= ZERO_WORD;
            if_pc_o    <= ZERO_WORD;
            mem_rd_o   <= 1'b0;
            mem_addr_o <= ZERO_WORD;
        end else begin
            // A grant during a redirect cycle is dropped along with the fetch.
            in_flight  <= granted && !branch_sig_i;
            flight_tag <= req_k;

            if (in_flight && !branch_sig_i) begin
                case (flight_tag)
                    2'd0:    if_inst_o[7:0]   <= mem_data_i;
                    2'd1:    if_inst_o[15:8]  <= mem_data_i;
                    2'd2:    if_inst_o[23:16] <= mem_data_i;
                    default: if_inst_o[31:24] <= mem_data_i;
                endcase
            end

            if (branch_sig_i) begin
                state      <= IF_REQ0;
                pc         <= branch_pc;
                if_valid_o <= 1'b0;
                mem_rd_o   <= 1'b1;
                mem_addr_o <= branch_pc;
            end else begin
                case (state)
                    IF_REQ0, IF_REQ1, IF_REQ2, IF_REQ3: begin
                        if (granted && state == IF_REQ3) begin
                            state    <= IF_WAIT;
                            mem_rd_o <= 1'b0;
                        end else if (granted) begin
                            state      <= req_next(state);
                            mem_rd_o   <= 1'b1;
                            mem_addr_o <= pc + INST_ADDR_W'(req_k) + INST_ADDR_W'(1);
                        end else begin
                            mem_rd_o   <= 1'b1;
                            mem_addr_o <= pc + INST_ADDR_W'(req_k);
                        end
                    end
                    IF_WAIT: begin
                        state      <= IF_VALID;
                        if_valid_o <= 1'b1;
                        if_pc_o    <= pc + INST_ADDR_W'(4);
                    end
                    IF_VALID: begin
                        // No prefetch: the next fetch starts only after accept.
                        if (!stall_i) begin
                            state      <= IF_REQ0;
                            if_valid_o <= 1'b0;
                            pc         <= pc + INST_ADDR_W'(4);
                            mem_rd_o   <= 1'b1;
                            mem_addr_o <= pc + INST_ADDR_W'(4);
                        end
                    end
                    default: begin
                        state    <= IF_REQ0;
                        mem_rd_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed vector table, hand-written
// corner sequences, then random grants/stalls/redirects against a model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_sig;
    logic [31:0] branch_addr;
    logic        stall;
    logic        gnt;
    logic [7:0]  mem_data;
    logic [7:0]  mem_data_w;

    logic        mem_rd,   mem_rd_w;
    logic [31:0] mem_addr, mem_addr_w;
    logic        if_valid, if_valid_w;
    logic [31:0] if_pc,    if_pc_w;
    logic [31:0] if_inst,  if_inst_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .branch_sig_i(branch_sig), .branch_addr_i(branch_addr),
        .stall_i(stall), .mem_gnt_i(gnt), .mem_data_i(mem_data),
        .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .if_valid_o(if_valid),
        .if_pc_o(if_pc), .if_inst_o(if_inst)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .branch_sig_i(branch_sig), .branch_addr_i(branch_addr),
        .stall_i(stall), .mem_gnt_i(gnt), .mem_data_i(mem_data_w),
        .mem_rd_o(mem_rd_w), .mem_addr_o(mem_addr_w), .if_valid_o(if_valid_w),
        .if_pc_o(if_pc_w), .if_inst_o(if_inst_w)
    );

    // Memory image: a few fixed instructions at 0..7, hashed bytes elsewhere.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'd0: return 8'h13;
            32'd1: return 8'h00;
            32'd2: return 8'h00;
            32'd3: return 8'h00;
            32'd4: return 8'h93;
            32'd5: return 8'h00;
            32'd6: return 8'h10;
            32'd7: return 8'h00;
            default: begin
                h = a * 32'd2654435761;
                return h[31:24] ^ a[7:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock; the memory answers a granted request on the following cycle
    // and drives junk otherwise.
    task automatic cycle();
        logic        g, gw;
        logic [31:0] a, aw;
        g  = mem_rd && gnt;
        a  = mem_addr;
        gw = mem_rd_w && gnt;
        aw = mem_addr_w;
        @(posedge clk);
        #1;
        mem_data   = g  ? mem_byte(a)  : 8'($urandom);
        mem_data_w = gw ? mem_byte(aw) : 8'($urandom);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " rd"},    32'(mem_rd),   32'd0);
        check({tag, " addr"},  mem_addr,      32'd0);
        check({tag, " valid"}, 32'(if_valid), 32'd0);
        check({tag, " pc"},    if_pc,         32'd0);
        check({tag, " inst"},  if_inst,       32'd0);
    endtask

    // From a cycle requesting byte 0 at base with grants held high, run to
    // VALID and check the presented instruction; returns in the VALID cycle.
    task automatic run_fetch(input logic [31:0] base, input string tag);
        gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check({tag, " req rd"},   32'(mem_rd), 32'd1);
            check({tag, " req addr"}, mem_addr,    base + 32'(k));
            cycle();
        end
        check({tag, " wait rd"},    32'(mem_rd),   32'd0);
        check({tag, " wait valid"}, 32'(if_valid), 32'd0);
        cycle();
        check({tag, " valid"}, 32'(if_valid), 32'd1);
        check({tag, " pc"},    if_pc,         base + 32'd4);
        check({tag, " inst"},  if_inst,       mem_word(base));
    endtask

    typedef struct {
        logic        gnt;
        logic        stall;
        logic        rd;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    function automatic vec_t mk(input logic g, input logic s, input logic rd,
                                input logic [31:0] addr, input logic v,
                                input logic [31:0] pc, input logic [31:0] inst);
        vec_t r;
        r.gnt = g; r.stall = s; r.rd = rd; r.addr = addr;
        r.valid = v; r.pc = pc; r.inst = inst;
        return r;
    endfunction

    vec_t vecs[18];

    // Random-phase reference: pc of the instruction being fetched, bytes
    // granted so far, and where the fetched word sits in its 2-cycle drain.
    logic [31:0] m_pc;
    int          m_bytes;
    logic        m_wait;
    logic        m_valid;

    initial begin
        vecs[0]  = mk(1, 0, 0, 32'd0, 0, 32'd0, 32'd0);
        vecs[1]  = mk(1, 0, 1, 32'd0, 0, 32'd0, 32'd0);
        vecs[2]  = mk(1, 0, 1, 32'd1, 0, 32'd0, 32'd0);
        vecs[3]  = mk(1, 0, 1, 32'd2, 0, 32'd0, 32'd0);
        vecs[4]  = mk(1, 0, 1, 32'd3, 0, 32'd0, 32'd0);
        vecs[5]  = mk(1, 1, 0, 32'd0, 0, 32'd0, 32'd0);
        vecs[6]  = mk(1, 1, 0, 32'd0, 1, 32'd4, 32'h0000_0013);
        vecs[7]  = mk(1, 1, 0, 32'd0, 1, 32'd4, 32'h0000_0013);
        vecs[8]  = mk(1, 1, 0, 32'd0, 1, 32'd4, 32'h0000_0013);
        vecs[9]  = mk(1, 0, 0, 32'd0, 1, 32'd4, 32'h0000_0013);
        vecs[10] = mk(1, 0, 1, 32'd4, 0, 32'd0, 32'd0);
        vecs[11] = mk(1, 0, 1, 32'd5, 0, 32'd0, 32'd0);
        vecs[12] = mk(0, 0, 1, 32'd6, 0, 32'd0, 32'd0);
        vecs[13] = mk(0, 0, 1, 32'd6, 0, 32'd0, 32'd0);
        vecs[14] = mk(1, 0, 1, 32'd6, 0, 32'd0, 32'd0);
        vecs[15] = mk(1, 0, 1, 32'd7, 0, 32'd0, 32'd0);
        vecs[16] = mk(1, 0, 0, 32'd0, 0, 32'd0, 32'd0);
        vecs[17] = mk(1, 0, 0, 32'd0, 1, 32'd8, 32'h0010_0093);

        rst = 1'b1; branch_sig = 1'b0; branch_addr = 32'd0;
        stall = 1'b0; gnt = 1'b0; mem_data = 8'd0; mem_data_w = 8'd0;
        cycle();
        cycle();
        check_reset("reset");
        check("reset_w addr", mem_addr_w, 32'd0);
        rst = 1'b0;

        // Basic fetch, stall hold, accept, and denied grants in REQ2.
        for (int i = 0; i < 18; i++) begin
            gnt   = vecs[i].gnt;
            stall = vecs[i].stall;
            check($sformatf("vec%0d rd", i),    32'(mem_rd),   32'(vecs[i].rd));
            check($sformatf("vec%0d valid", i), 32'(if_valid), 32'(vecs[i].valid));
            if (vecs[i].rd)
                check($sformatf("vec%0d addr", i), mem_addr, vecs[i].addr);
            if (vecs[i].valid) begin
                check($sformatf("vec%0d pc", i),   if_pc,   vecs[i].pc);
                check($sformatf("vec%0d inst", i), if_inst, vecs[i].inst);
            end
            cycle();
        end

        // Redirect one cycle after REQ1 is granted; the REQ2 grant is dropped.
        gnt = 1'b1; stall = 1'b0;
        check("br pre addr0", mem_addr, 32'd8);
        cycle();
        check("br pre addr1", mem_addr, 32'd9);
        cycle();
        branch_sig = 1'b1; branch_addr = 32'h0000_0103;
        cycle();
        branch_sig = 1'b0;
        run_fetch(32'h0000_0100, "br103");

        // Redirect in VALID without stall wins over the accept.
        branch_sig = 1'b1; branch_addr = 32'h0000_0200;
        cycle();
        branch_sig = 1'b0;
        check("brvalid valid", 32'(if_valid), 32'd0);
        run_fetch(32'h0000_0200, "br200");

        // Redirect together with stall in VALID.
        stall = 1'b1; branch_sig = 1'b1; branch_addr = 32'h0000_0302;
        cycle();
        stall = 1'b0; branch_sig = 1'b0;
        check("brstall valid", 32'(if_valid), 32'd0);
        run_fetch(32'h0000_0300, "br300");
        cycle();
        check("accept next addr", mem_addr, 32'h0000_0304);

        // Back-to-back redirects keep restarting the fetch.
        for (int i = 0; i < 4; i++) begin
            branch_sig  = 1'b1;
            branch_addr = 32'h0000_0400 + 32'(i * 16) + 32'd1;
            cycle();
            check($sformatf("chain%0d addr", i),  mem_addr,      32'h0000_0400 + 32'(i * 16));
            check($sformatf("chain%0d valid", i), 32'(if_valid), 32'd0);
        end
        branch_sig = 1'b0;
        run_fetch(32'h0000_0430, "chain");
        cycle();

        // Reset in the middle of REQ2.
        cycle();
        cycle();
        check("midrst req2 addr", mem_addr, 32'h0000_0436);
        rst = 1'b1;
        cycle();
        check_reset("midrst");
        rst = 1'b0;
        check("bubble rd", 32'(mem_rd), 32'd0);
        cycle();

        // Both instances restart: dut at 0, dut_w wraps through 2^32.
        for (int k = 0; k < 4; k++) begin
            check("rst req addr", mem_addr,   32'(k));
            check("wrap req rd",  32'(mem_rd_w), 32'd1);
            check("wrap req addr", mem_addr_w, 32'hFFFF_FFFC + 32'(k));
            cycle();
        end
        cycle();
        check("rst valid", 32'(if_valid), 32'd1);
        check("rst inst",  if_inst,       32'h0000_0013);
        check("wrap valid", 32'(if_valid_w), 32'd1);
        check("wrap pc",    if_pc_w,         32'd0);
        check("wrap inst",  if_inst_w,       mem_word(32'hFFFF_FFFC));
        cycle();
        check("wrap next addr", mem_addr_w, 32'd0);
        check("rst next addr",  mem_addr,   32'd4);

        // Random grants, stalls and redirects against the reference.
        m_pc = 32'd4; m_bytes = 0; m_wait = 1'b0; m_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            check("rnd rd",    32'(mem_rd),   32'(m_bytes < 4));
            check("rnd valid", 32'(if_valid), 32'(m_valid));
            if (m_bytes < 4)
                check("rnd addr", mem_addr, m_pc + 32'(m_bytes));
            if (m_valid) begin
                check("rnd pc",   if_pc,   m_pc + 32'd4);
                check("rnd inst", if_inst, mem_word(m_pc));
            end
            gnt         = ($urandom % 4) != 0;
            stall       = ($urandom % 3) == 0;
            branch_sig  = ($urandom % 12) == 0;
            branch_addr = $urandom;
            if (branch_sig) begin
                m_pc = {branch_addr[31:2], 2'b00};
                m_bytes = 0; m_wait = 1'b0; m_valid = 1'b0;
            end else if (m_bytes < 4) begin
                if (gnt) begin
                    m_bytes++;
                    m_wait = (m_bytes == 4);
                end
            end else if (m_wait) begin
                m_wait = 1'b0; m_valid = 1'b1;
            end else if (m_valid && !stall) begin
                m_valid = 1'b0; m_bytes = 0; m_pc = m_pc + 32'd4;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
